// File: rtl/code_queue_arbiter.sv
// code_queue_arbiter: round-robin drain of four lane FIFOs into code_queue, with end-of-stripe flush sequencing.
module code_queue_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_d,
  input  logic [15:0]      req_cx,
  output logic [3:0]       req_ready,
  input  logic             eof_req,
  output logic             wrreq,
  output logic             d_output,
  output logic [3:0]       cx_output,
  output logic             flush_out,
  output logic             eof_ack,
  output logic [CNT_W-1:0] sym_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, ACK} state_t;
  state_t state, state_nx;
  logic [4:0]    mem [4][FIFO_DEPTH];
  logic [PW-1:0] wptr [4];
  logic [PW-1:0] rptr [4];
  logic [CW-1:0] cnt [4];
  logic [3:0]    push, pop, ne;
  logic [1:0]    last_grant, gnt;
  logic          gv;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ne[i] = cnt[i] != '0;
      req_ready[i] = cnt[i] != CW'(FIFO_DEPTH) && state == IDLE;
      push[i] = req_valid[i] && req_ready[i];
    end
    // descending scan so the lane nearest last_grant+1 is assigned last and wins
    gnt = last_grant;
    for (int k = 4; k >= 1; k--)
      if (ne[last_grant + 2'(k)]) gnt = last_grant + 2'(k);
    gv = |ne;
    pop = gv ? 4'(4'b1 << gnt) : 4'b0;
  end
  always_comb begin
    state_nx = state;
    flush_out = state == FLUSH;
    eof_ack = state == ACK;
    case (state)
      IDLE:    state_nx = eof_req ? DRAIN : IDLE;
      DRAIN:   state_nx = gv ? DRAIN : FLUSH;
      FLUSH:   state_nx = ACK;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (push[i]) mem[i][wptr[i]] <= {req_d[i], req_cx[4*i +: 4]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 2'd3;
      wrreq <= 1'b0;
      d_output <= 1'b0;
      cx_output <= '0;
      sym_count <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      state <= state_nx;
      wrreq <= gv;
      sym_count <= sym_count + CNT_W'(gv);
      if (gv) begin
        last_grant <= gnt;
        {d_output, cx_output} <= mem[gnt][rptr[gnt]];
      end
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PW'(1);
        if (pop[i]) rptr[i] <= rptr[i] + PW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end
endmodule

// File: tb/tb_code_queue_arbiter.sv
// tb_code_queue_arbiter: directed vectors with hand-computed issue order and flush timing.
module tb_code_queue_arbiter;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  req_valid = 0, req_d = 0;
  logic [15:0] req_cx = 0;
  logic        eof_req = 0;
  logic [3:0]  req_ready, cx_output;
  logic        wrreq, d_output, flush_out, eof_ack;
  logic [15:0] sym_count;
  int errs = 0, checks = 0;
  logic [4:0] log_q[$];
  int nflush = 0, nack = 0, cnum = 0, flush_at = 0, ack_at = 0, flush_log = 0;
  logic flush_wr = 0;

  code_queue_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_d(req_d), .req_cx(req_cx),
    .req_ready(req_ready), .eof_req(eof_req), .wrreq(wrreq), .d_output(d_output),
    .cx_output(cx_output), .flush_out(flush_out), .eof_ack(eof_ack), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cnum++;
    if (wrreq) log_q.push_back({d_output, cx_output});
    if (flush_out) begin
      nflush++;
      flush_at = cnum;
      flush_wr = wrreq;
      flush_log = log_q.size();
    end
    if (eof_ack) begin
      nack++;
      ack_at = cnum;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    req_valid = 0;
    eof_req = 0;
    #3 rst_n = 1;
    cyc();
    log_q.delete();
    nflush = 0;
    nack = 0;
  endtask

  task automatic check_log(input string tag, input logic [4:0] exp[]);
    check({tag, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), log_q[i], exp[i]);
  endtask

  initial begin
    cyc();
    do_reset();
    check("rst_ready", req_ready, 4'hf);
    check("rst_wrreq", wrreq, 0);
    check("rst_sym", sym_count, 0);
    check("rst_flush", {flush_out, eof_ack, d_output, cx_output}, 0);

    // lane 0 alone: d=0,0,1,1 cx=4
    req_valid = 4'b0001; req_cx = 16'h0004; req_d = 0;
    cyc(); check("t1_lat", wrreq, 0);
    req_d = 0; cyc(); check("t1_s0", {wrreq, d_output, cx_output}, 6'h24);
    req_d = 1; cyc(); check("t1_s1", {wrreq, d_output, cx_output}, 6'h24);
    req_d = 1; cyc(); check("t1_s2", {wrreq, d_output, cx_output}, 6'h34);
    req_valid = 0; cyc(); check("t1_s3", {wrreq, d_output, cx_output}, 6'h34);
    cyc(); check("t1_end", wrreq, 0);
    check("t1_sym", sym_count, 4);

    // simultaneous bursts on all lanes
    do_reset();
    req_valid = 4'hf; req_d = 4'b1010; req_cx = 16'h4321;
    cyc(); req_valid = 0;
    repeat (6) cyc();
    check_log("t2a", '{5'h01, 5'h12, 5'h03, 5'h14});
    log_q.delete();
    req_valid = 4'hf;
    cyc(); req_valid = 0;
    repeat (6) cyc();
    check_log("t2b", '{5'h01, 5'h12, 5'h03, 5'h14});

    // lane 2 held for 6 cycles against one pair on each other lane
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req_valid = (k == 0) ? 4'b1111 : 4'b0100;
      req_d = {1'b0, 1'(k), 2'b00};
      req_cx = {4'h3, 4'(8 + k), 4'h2, 4'h1};
      cyc();
      if (k == 3) check("t3_ready_open", req_ready[2], 1);
      if (k == 4) check("t3_ready_full", req_ready[2], 0);
    end
    req_valid = 0;
    repeat (10) cyc();
    check_log("t3", '{5'h01, 5'h02, 5'h08, 5'h03, 5'h19, 5'h0a, 5'h1b, 5'h0c});

    // three pairs per lane, then stripe flush
    do_reset();
    req_d = 0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'hf;
      req_cx = {4'(12 + k), 4'(8 + k), 4'(4 + k), 4'(k)};
      cyc();
    end
    req_valid = 0; eof_req = 1;
    cyc(); eof_req = 0;
    check("t4_ready_closed", req_ready, 0);
    for (int t = 0; t < 40 && nack == 0; t++) cyc();
    check("t4_ack_seen", nack, 1);
    check("t4_flush_once", nflush, 1);
    check("t4_flush_wrreq", flush_wr, 0);
    check("t4_flush_after_all", flush_log, 12);
    check("t4_ack_follows", ack_at - flush_at, 1);
    check("t4_ready_reopen", req_ready, 4'hf);
    check("t4_sym", sym_count, 12);
    check_log("t4", '{5'h00, 5'h04, 5'h08, 5'h0c, 5'h01, 5'h05, 5'h09, 5'h0d,
                      5'h02, 5'h06, 5'h0a, 5'h0e});

    // async reset during DRAIN with partially full FIFOs
    do_reset();
    req_d = 4'hf; req_cx = 16'hffff; req_valid = 4'hf;
    cyc(); cyc();
    req_valid = 0; eof_req = 1;
    cyc(); eof_req = 0;
    check("t5_pre_wrreq", wrreq, 1);
    rst_n = 0;
    #1;
    check("t5_rst_out", {wrreq, d_output, cx_output, flush_out, eof_ack}, 0);
    check("t5_rst_ready", req_ready, 4'hf);
    check("t5_rst_sym", sym_count, 0);
    #2 rst_n = 1;
    log_q.delete(); nflush = 0;
    repeat (10) cyc();
    check("t5_no_stale", log_q.size(), 0);
    check("t5_no_flush", nflush, 0);

    // lane 1 streams continuously, lane 3 holds one pair
    do_reset();
    req_d = 0;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k == 0) ? 4'b1010 : 4'b0010;
      req_cx = {4'h3, 4'h0, 4'(5 + k), 4'h0};
      cyc();
      check($sformatf("t6_ready1_%0d", k), req_ready[1], 1);
    end
    req_valid = 0;
    repeat (6) cyc();
    check_log("t6", '{5'h05, 5'h03, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0a, 5'h0b, 5'h0c});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/code_queue_arbiter.md
# code_queue_arbiter

Round-robin scheduler that shares the single decision/context input of `code_queue` among four context-modeling lanes of the image coder. Each lane pushes (decision bit, 4-bit context) pairs into a private 4-entry FIFO. The arbiter drains the FIFOs one pair per cycle into `code_queue` through registered `wrreq/d/cx` outputs. It also sequences an end-of-stripe flush: block new input, drain all lanes, then pulse `flush_out` to the coder.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries per lane FIFO; power of two, ≥2.
- `CNT_W`, 16: width of the granted-symbol counter.

Ports (clock and reset first):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  4  per-lane push request.
- `req_d`  in  4  per-lane decision bit; lane i uses bit i.
- `req_cx`  in  16  per-lane context; lane i uses bits [4i+3:4i].
- `req_ready`  out  4  per-lane "may push".
- `eof_req`  in  1  one-cycle pulse requesting a stripe flush.
- `wrreq`  out  1  strobe to `code_queue`.
- `d_output`  out  1  decision bit to `code_queue`.
- `cx_output`  out  4  context to `code_queue`.
- `flush_out`  out  1  one-cycle flush pulse to `code_queue`.
- `eof_ack`  out  1  one-cycle pulse when the flush sequence completes.
- `sym_count`  out  CNT_W  number of pairs issued since reset.

## Operation
- A push occurs on lane i when `req_valid[i] && req_ready[i]` at a rising edge.
- `req_ready[i] = (count_i != FIFO_DEPTH) && state==IDLE`. This is combinational from registers only and does not depend on a same-cycle pop.
- Each FIFO has a `$clog2(FIFO_DEPTH)+1`-bit count and wrapping read/write pointers. Same-cycle push and pop on one lane leave the count unchanged.
- Arbitration is combinational each cycle over the non-empty lanes. The grant goes to the first non-empty lane searching upward from `last_grant+1` modulo 4. On a grant, the head is popped and `last_grant` updates to the granted lane.
- At most one pop per cycle. The granted pair is registered onto `d_output/cx_output` with `wrreq=1`. With no grant, `wrreq=0` and `d_output/cx_output` hold their last value.
- `sym_count` increments by 1 per issued pair and wraps modulo 2^CNT_W.
- Flush FSM:
  - IDLE -> DRAIN on `eof_req`. While in DRAIN, `req_ready=0` for all lanes, and a push presented in the same cycle as `eof_req` is still accepted.
  - DRAIN -> FLUSH when all counts are 0 and no pop occurs this cycle. Arbitration continues during DRAIN.
  - FLUSH: `flush_out=1` for exactly one cycle, with `wrreq=0` in that cycle. Then go to ACK.
  - ACK: `eof_ack=1` for one cycle. Then go to IDLE, and `req_ready` reopens.
  - `eof_req` outside IDLE is ignored.

## Timing
- Reset values:
  - Outputs: `wrreq=0`, `d_output=0`, `cx_output=0`, `flush_out=0`, `eof_ack=0`, `sym_count=0`, `req_ready=4'b1111`.
  - Internal: all counts and pointers 0, `last_grant=3` so lane 0 wins first, state=IDLE.
- Latency: a pair pushed at edge E into an empty, uncontended system appears with `wrreq=1` after edge E+1, i.e. 2 cycles push-to-strobe.
- Throughput: one pair per cycle aggregate. Each lane is guaranteed one grant in every 4 cycles while it is non-empty.
- Output ordering within a lane is strict FIFO order.
- Flush timing with empty FIFOs: `eof_req` at edge E gives DRAIN after E, FLUSH after E+1 (`flush_out` high), and ACK after E+2.
- Asserting `rst_n` low mid-operation clears all FIFO contents and the FSM immediately, with no flush pulse. Entries in flight are discarded.

## Test plan
- Lane 0 alone pushes bits 0,0,1,1 with cx=4 on consecutive cycles -> `wrreq` high for 4 consecutive cycles starting 2 cycles after the first push, with d=0,0,1,1, cx=4, and `sym_count` ending at 4.
- All four lanes push one pair in the same cycle (cx=1,2,3,4) -> issue order lanes 0,1,2,3 on 4 consecutive strobes. A second simultaneous burst issues in order 0,1,2,3 again.
- Hold `req_valid[2]=1` for 6 cycles while other lanes each have one pending pair:
  - `req_ready[2]` drops when the count reaches 4, and no pair is lost or duplicated.
  - The lane-2 output sequence matches the push sequence.
- Load 3 pairs per lane, then pulse `eof_req`:
  - `req_ready=0` from the next cycle.
  - All 12 pairs issue, then `flush_out` pulses once with `wrreq=0`, then `eof_ack` pulses on the following cycle.
  - `req_ready` returns to 4'b1111.
- Assert `rst_n` low while the FIFOs are partially full and in DRAIN -> all outputs return to their reset values asynchronously. After release, no stale pair is issued.
- Keep lane 1 continuously streaming with simultaneous push and pop -> its count stays constant. Lane 3, with one pending pair, is granted within 4 cycles.
